program_counter_ras: RTL and testbench

Parametrised fetch-stage program counter that generalises the plain load/hold PC. It has a configurable width, reset vector and increment, plus stall and redirect controls. It also carries an integrated return-address stack (RAS) for call/return redirection. It sits between the branch/jump resolution logic and instruction memory, and drives the fetch address every cycle.

---
 rtl/program_counter_ras_if.sv | 29 ++
 rtl/program_counter_ras.sv | 85 ++++++++
 tb/tb_program_counter_ras.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/program_counter_ras_if.sv
// rtl/program_counter_ras_if.sv - fetch PC control/status bundle
// The master drives the redirect/call/return controls and the slave (the PC) returns fetch address and RAS status.
interface program_counter_ras_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             pc_ctrl;
  logic [WIDTH-1:0] pc_in;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [CW-1:0]    ras_count;
  logic             ras_full;
  logic             ras_empty;
  logic             ret_underflow;

  modport master (
    output stall, pc_ctrl, pc_in, call, ret,
    input  pc_out, ras_count, ras_full, ras_empty, ret_underflow
  );

  modport slave (
    input  stall, pc_ctrl, pc_in, call, ret,
    output pc_out, ras_count, ras_full, ras_empty, ret_underflow
  );
endinterface

// File: rtl/program_counter_ras.sv
// rtl/program_counter_ras.sv - fetch program counter with circular return-address stack
// Priority per edge: reset > stall > ret > call > pc_ctrl > increment; all outputs registered.
module program_counter_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] INC       = WIDTH'(4),
  parameter int               RAS_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  program_counter_ras_if.slave bus
);
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam int            CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [PW-1:0]    push_ptr;

  always_comb begin
    pc_d        = pc_q;
    top_d       = top_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    ras_d       = ras_q;
    seq_pc      = pc_q + INC;
    push_ptr    = top_q + 1'b1;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (count_q != '0) begin
          pc_d    = ras_q[top_q];
          top_d   = top_q - 1'b1;
          count_d = count_q - 1'b1;
        end else begin
          pc_d        = seq_pc;
          underflow_d = 1'b1;
        end
      end else if (bus.call) begin
        // A full stack keeps its count; the pointer wrap overwrites the oldest entry.
        ras_d[push_ptr] = seq_pc;
        top_d           = push_ptr;
        pc_d            = bus.pc_in;
        if (count_q != FULL_CNT) begin
          count_d = count_q + 1'b1;
        end
      end else if (bus.pc_ctrl) begin
        pc_d = bus.pc_in;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_VEC;
      top_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc_out        = pc_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_full      = (count_q == FULL_CNT);
  assign bus.ras_empty     = (count_q == '0);
  assign bus.ret_underflow = underflow_q;
endmodule

// File: tb/tb_program_counter_ras.sv
// tb/tb_program_counter_ras.sv - scoreboard bench for program_counter_ras
// A queue-based reference model predicts each cycle's outputs; a monitor compares them after every edge.
module tb_program_counter_ras;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] pc;
    int               cnt;
    bit               uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  exp_t             exp_q [$];
  logic [WIDTH-1:0] m_ras [$];
  logic [WIDTH-1:0] m_pc = '0;

  program_counter_ras_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  program_counter_ras #(
    .WIDTH(WIDTH), .RESET_VEC('0), .INC(32'd4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction for the following edge.
  task automatic step(input bit r, input bit s, input bit pcc, input logic [WIDTH-1:0] pin,
                      input bit c, input bit rt);
    exp_t e;
    bit   uf;
    @(negedge clk);
    rst_n       = r;
    bus.stall   = s;
    bus.pc_ctrl = pcc;
    bus.pc_in   = pin;
    bus.call    = c;
    bus.ret     = rt;
    uf = 1'b0;
    if (!r) begin
      m_pc = '0;
      m_ras.delete();
    end else if (s) begin
      uf = 1'b0;
    end else if (rt) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = m_pc + 32'd4;
        uf   = 1'b1;
      end
    end else if (c) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      m_pc = pin;
    end else if (pcc) begin
      m_pc = pin;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc  = m_pc;
    e.cnt = m_ras.size();
    e.uf  = uf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out",        bus.pc_out,                  e.pc);
        chk("ras_count",     WIDTH'(bus.ras_count),       WIDTH'(e.cnt));
        chk("ras_full",      WIDTH'(bus.ras_full),        WIDTH'(e.cnt == DEPTH));
        chk("ras_empty",     WIDTH'(bus.ras_empty),       WIDTH'(e.cnt == 0));
        chk("ret_underflow", WIDTH'(bus.ret_underflow),   WIDTH'(e.uf));
      end
    end
  end

  initial begin : stimulus
    logic [WIDTH-1:0] pin;
    rst_n       = 1'b0;
    bus.stall   = 1'b0;
    bus.pc_ctrl = 1'b0;
    bus.pc_in   = '0;
    bus.call    = 1'b0;
    bus.ret     = 1'b0;

    // Reset and sequential run
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    idle(3);

    // Redirect, stall hold, stalled redirect ignored
    step(1, 0, 1, 32'd5, 0, 0);
    step(1, 0, 0, 32'd13, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0, 0);
    step(1, 1, 1, 32'h40, 0, 0);
    step(1, 1, 0, 32'h80, 1, 1);

    // Call and return
    step(1, 0, 1, 32'h100, 0, 0);
    step(1, 0, 0, 32'h200, 1, 0);
    idle(2);
    step(1, 0, 0, '0, 0, 1);

    // Overflow then underflow
    step(1, 0, 1, 32'h10, 0, 0);
    for (int i = 2; i <= 6; i++) step(1, 0, 0, WIDTH'(i * 16), 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, 0, 1);
    step(1, 0, 0, '0, 0, 1);

    // call+ret together, pc_ctrl ignored alongside call, address wrap
    step(1, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 32'h400, 1, 0);
    step(1, 0, 1, 32'h900, 1, 1);
    step(1, 0, 1, 32'h700, 1, 0);
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(1);

    // Reset mid-operation
    step(1, 0, 1, 32'h600, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h600, 1, 0);
    step(1, 0, 1, 32'h500, 0, 0);
    step(0, 0, 0, 32'h800, 1, 0);
    step(1, 0, 0, '0, 0, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      pin = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | WIDTH'($urandom_range(0, 15)))
                                        : WIDTH'($urandom);
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0,
           pin,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
